// File: rtl/lstm_cell_update.sv
// lstm_cell_update: consumes one timestep of gate results, updates the held
// cell state c element by element and produces the hidden vector h through a
// two-stage pipeline (stage 1: cell update, stage 2: hard-tanh and output gate).
module lstm_cell_update #(
  parameter int dataWidth  = 16,
  parameter int fracWidth  = 12,
  parameter int hiddenSize = 15
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        clearState,
  input  logic [(2*dataWidth+1)*hiddenSize-1:0]       fGate,
  input  logic [(2*dataWidth+1)*hiddenSize-1:0]       iGate,
  input  logic [(2*dataWidth+1)*hiddenSize-1:0]       gGate,
  input  logic [(2*dataWidth+1)*hiddenSize-1:0]       oGate,
  output logic [dataWidth*hiddenSize-1:0]             c,
  output logic [dataWidth*hiddenSize-1:0]             h,
  output logic                                        busy,
  output logic                                        done
);

  localparam int GW = 2*dataWidth + 1;
  localparam int KW = (hiddenSize > 1) ? $clog2(hiddenSize) : 1;

  // Saturation bounds expressed at the wide (gate/sum) width
  localparam logic signed [GW-1:0] SAT_MAX = {{(GW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [GW-1:0] SAT_MIN = {{(GW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};
  // Hard-tanh limits: +/- 1.0 in Q(dataWidth-fracWidth).fracWidth
  localparam logic signed [dataWidth-1:0] HT_MAX = {{(dataWidth-fracWidth-1){1'b0}}, 1'b1, {fracWidth{1'b0}}};
  localparam logic signed [dataWidth-1:0] HT_MIN = {{(dataWidth-fracWidth){1'b1}}, {fracWidth{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic [GW*hiddenSize-1:0] f_snap, i_snap, g_snap, o_snap;

  logic                          s1_valid;
  logic [KW-1:0]                 s1_k;
  logic signed [dataWidth-1:0]   s1_c;

  logic signed [GW-1:0]          f_el, i_el, g_el, o_el, sum;
  logic signed [dataWidth-1:0]   qf, qi, qg, qo, c_old, c_new, ht, h_new;
  logic signed [2*dataWidth-1:0] p_fc, p_ig, p_oh;

  // Floor shift by fracWidth, then saturate to the dataWidth signed range.
  // Used for gate requantization and for both product rescales.
  function automatic logic signed [dataWidth-1:0] shift_sat(input logic signed [GW-1:0] x);
    logic signed [GW-1:0] s;
    s = x >>> fracWidth;
    if (s > SAT_MAX)      shift_sat = SAT_MAX[dataWidth-1:0];
    else if (s < SAT_MIN) shift_sat = SAT_MIN[dataWidth-1:0];
    else                  shift_sat = s[dataWidth-1:0];
  endfunction

  // Stage 1 datapath: new cell value for element k
  always_comb begin
    f_el  = f_snap[GW*k +: GW];
    i_el  = i_snap[GW*k +: GW];
    g_el  = g_snap[GW*k +: GW];
    c_old = c[dataWidth*k +: dataWidth];
    qf    = shift_sat(f_el);
    qi    = shift_sat(i_el);
    qg    = shift_sat(g_el);
    p_fc  = qf * c_old;
    p_ig  = qi * qg;
    sum   = GW'(p_fc) + GW'(p_ig);
    c_new = shift_sat(sum);
  end

  // Stage 2 datapath: hard tanh of the piped cell value times the output gate
  always_comb begin
    o_el = o_snap[GW*s1_k +: GW];
    qo   = shift_sat(o_el);
    if (s1_c > HT_MAX)      ht = HT_MAX;
    else if (s1_c < HT_MIN) ht = HT_MIN;
    else                    ht = s1_c;
    p_oh  = qo * ht;
    h_new = shift_sat(GW'(p_oh));
  end

  // Control FSM: gate snapshot, element counter, busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      f_snap <= '0;
      i_snap <= '0;
      g_snap <= '0;
      o_snap <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            f_snap <= fGate;
            i_snap <= iGate;
            g_snap <= gGate;
            o_snap <= oGate;
            k      <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (k == KW'(hiddenSize - 1)) state <= S_DRAIN;
          else                          k     <= k + KW'(1);
        end
        S_DRAIN: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath registers: cell state, stage-1 pipe register, hidden vector
  always_ff @(posedge clk) begin
    if (rst) begin
      c        <= '0;
      h        <= '0;
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_c     <= '0;
    end else begin
      s1_valid <= (state == S_RUN);
      s1_k     <= k;
      s1_c     <= c_new;
      if (state == S_IDLE && clearState) c <= '0;
      else if (state == S_RUN)           c[dataWidth*k +: dataWidth] <= c_new;
      if (s1_valid) h[dataWidth*s1_k +: dataWidth] <= h_new;
    end
  end

endmodule

// File: tb/tb_lstm_cell_update.sv
// Self-checking bench for lstm_cell_update: directed timesteps push expected
// (c, h) into a scoreboard; a monitor pops and compares on every done pulse.
module tb_lstm_cell_update;
  localparam int DW = 16;
  localparam int FW = 12;
  localparam int HS = 15;
  localparam int GW = 2*DW + 1;

  logic clk = 1'b0;
  logic rst, start, clearState;
  logic [GW*HS-1:0] fGate, iGate, gGate, oGate;
  logic [DW*HS-1:0] c, h;
  logic busy, done;

  typedef struct { logic signed [DW-1:0] ec; logic signed [DW-1:0] eh; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  lstm_cell_update #(.dataWidth(DW), .fracWidth(FW), .hiddenSize(HS)) dut (
    .clk(clk), .rst(rst), .start(start), .clearState(clearState),
    .fGate(fGate), .iGate(iGate), .gGate(gGate), .oGate(oGate),
    .c(c), .h(h), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gates(input logic signed [GW-1:0] fv, iv, gv, ov);
    for (int e = 0; e < HS; e++) begin
      fGate[GW*e +: GW] = fv;
      iGate[GW*e +: GW] = iv;
      gGate[GW*e +: GW] = gv;
      oGate[GW*e +: GW] = ov;
    end
  endtask

  // One timestep: push expectation, issue start, check busy/done timing per cycle
  task automatic run_update(input logic signed [GW-1:0] fv, iv, gv, ov, input logic clr,
                            input logic signed [DW-1:0] ec, eh, input bit chk_pipe);
    exp_t e;
    e.ec = ec;
    e.eh = eh;
    set_gates(fv, iv, gv, ov);
    sb.push_back(e);
    start = 1'b1;
    clearState = clr;
    tick();
    start = 1'b0;
    clearState = 1'b0;
    set_gates('1, '1, '1, '1);  // upstream moves on; snapshot must hold
    for (int n = 1; n <= 17; n++) begin
      check("busy_run", busy, 1);
      check("done_timing", done, (n == 17));
      if (chk_pipe && n == 2) begin
        check("c0_cycle2", $signed(c[0 +: DW]), ec);
        check("c1_cycle2", $signed(c[DW +: DW]), 0);
        check("h0_cycle2", $signed(h[0 +: DW]), 0);
      end
      if (chk_pipe && n == 3) check("h0_cycle3", $signed(h[0 +: DW]), eh);
      tick();
    end
    check("busy_after", busy, 0);
    check("done_after", done, 0);
  endtask

  // Monitor: compare every element of c and h against the scoreboard on done
  initial begin
    exp_t e;
    forever begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          for (int k = 0; k < HS; k++) begin
            check($sformatf("c[%0d]", k), $signed(c[DW*k +: DW]), e.ec);
            check($sformatf("h[%0d]", k), $signed(h[DW*k +: DW]), e.eh);
          end
        end
      end
    end
  end

  localparam logic signed [GW-1:0] ONE  = 33'sd16777216;   // 1.0 at 2*FW frac bits
  localparam logic signed [GW-1:0] HALF = 33'sd8388608;    // 0.5
  localparam logic signed [GW-1:0] BIG  = 33'sd1073741824; // 2^30
  localparam logic signed [GW-1:0] ZERO = 33'sd0;
  localparam logic signed [GW-1:0] NEG1 = -33'sd1;

  initial begin
    int base;
    rst = 1'b1;
    start = 1'b1;
    clearState = 1'b0;
    set_gates(ONE, ONE, HALF, ONE);
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_c", (c == '0), 1);
    check("rst_h", (h == '0), 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    tick();
    check("start_in_rst_ignored", busy, 0);

    // Accumulation and hard-tanh clamp
    run_update(ONE, ONE, HALF, ONE, 1'b1, 16'sd2048, 16'sd2048, 1'b1);
    run_update(ONE, ONE, HALF, ONE, 1'b0, 16'sd4096, 16'sd4096, 1'b0);
    run_update(ONE, ONE, HALF, ONE, 1'b0, 16'sd6144, 16'sd4096, 1'b0);
    // Saturation, then saturation again without wrap
    run_update(ZERO, ONE, BIG, ONE, 1'b1, 16'sd32767, 16'sd4096, 1'b0);
    run_update(ONE, ONE, BIG, ONE, 1'b0, 16'sd32767, 16'sd4096, 1'b0);
    // Negative floor
    run_update(ZERO, ONE, NEG1, ONE, 1'b1, -16'sd1, -16'sd1, 1'b0);

    // start+clearState pulse in cycle 5 of a busy update must be ignored
    begin
      exp_t e;
      e.ec = 16'sd2048;
      e.eh = 16'sd2048;
      base = n_done;
      set_gates(ONE, ONE, HALF, ONE);
      sb.push_back(e);
      start = 1'b1;
      clearState = 1'b1;
      tick();
      for (int n = 1; n <= 24; n++) begin
        start = (n == 5);
        clearState = (n == 5);
        tick();
      end
      start = 1'b0;
      clearState = 1'b0;
      check("busy_start_single_done", n_done - base, 1);
      check("busy_start_idle", busy, 0);
    end

    // rst in cycle 8 aborts with no done and zeroed outputs
    base = n_done;
    set_gates(ONE, ONE, HALF, ONE);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 7; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_c", (c == '0), 1);
    check("abort_h", (h == '0), 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int n = 0; n < 20; n++) tick();
    check("abort_no_done", n_done - base, 0);

    // Fresh update after the abort
    run_update(ONE, ONE, HALF, ONE, 1'b0, 16'sd2048, 16'sd2048, 1'b0);
    tick();
    tick();
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
